// File: rtl/fp_pkg.sv
// Shared IEEE-754 single-precision types and helpers for the fp compare/reduce blocks.
package fp_pkg;

  localparam logic [31:0] FP_NAN_CANON = 32'h7FC0_0000;

  typedef struct packed {
    logic        sign;
    logic [7:0]  exp;
    logic [22:0] mant;
  } fp32_t;

  typedef enum logic [1:0] {IDLE, ACCUM, OUT} reduce_state_t;

  function automatic logic is_nan(fp32_t f);
    return (f.exp == 8'hFF) && (f.mant != '0);
  endfunction

endpackage

// File: rtl/fp_gt_cmp.sv
// Combinational a>b on IEEE-754 singles; +0 and -0 compare equal, NaNs never win.
module fp_gt_cmp
  import fp_pkg::*;
(
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        gt,
  output logic        a_nan,
  output logic        b_nan
);

  fp32_t fa, fb;
  logic  both_zero;
  logic  mag_gt;
  logic  mag_lt;

  assign fa        = a;
  assign fb        = b;
  assign a_nan     = is_nan(fa);
  assign b_nan     = is_nan(fb);
  assign both_zero = (a[30:0] == '0) && (b[30:0] == '0);
  assign mag_gt    = a[30:0] > b[30:0];
  assign mag_lt    = a[30:0] < b[30:0];

  always_comb begin
    gt = 1'b0;
    if (a_nan || b_nan)
      gt = 1'b0;
    else if (fa.sign != fb.sign)
      gt = !fa.sign && !both_zero;
    else if (!fa.sign)
      gt = mag_gt;
    else
      gt = mag_lt;
  end

endmodule

// File: rtl/fp_max_reduce.sv
// Streaming max-reduction over an s_last-delimited vector of singles; returns max, its
// index and a NaN-seen flag one cycle after the final beat.
module fp_max_reduce
  import fp_pkg::*;
#(
  parameter int MAX_LEN = 1024,
  parameter int IDX_W   = $clog2(MAX_LEN)
) (
  input  logic             aclk,
  input  logic             aresetn,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [31:0]      s_data,
  input  logic             s_last,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [31:0]      m_max,
  output logic [IDX_W-1:0] m_index,
  output logic             m_nan
);

  reduce_state_t    state, state_nxt;
  logic [IDX_W-1:0] count;
  logic [31:0]      max_q, max_nxt;
  logic [IDX_W-1:0] idx_q, idx_nxt;
  logic             nan_q, nan_nxt;
  logic             have_q, have_nxt;
  logic             gt, d_nan, max_nan;
  logic             accept, last_beat, take;

  fp_gt_cmp u_cmp (
    .a     (s_data),
    .b     (max_q),
    .gt    (gt),
    .a_nan (d_nan),
    .b_nan (max_nan)
  );

  // s_ready is held low for the whole reset assertion, not just after the first edge
  assign s_ready   = aresetn && (state != OUT);
  assign accept    = s_valid && s_ready;
  assign last_beat = s_last || (count == IDX_W'(MAX_LEN - 1));
  assign take      = !d_nan && (!have_q || max_nan || gt);

  always_comb begin
    max_nxt  = max_q;
    idx_nxt  = idx_q;
    nan_nxt  = nan_q || d_nan;
    have_nxt = have_q;
    if (take) begin
      max_nxt  = s_data;
      idx_nxt  = count;
      have_nxt = 1'b1;
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = last_beat ? OUT : ACCUM;
      ACCUM:   if (accept && last_beat) state_nxt = OUT;
      OUT:     if (m_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Accumulators are zero in IDLE, so the first beat loads through the normal update path
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      count   <= '0;
      max_q   <= '0;
      idx_q   <= '0;
      nan_q   <= 1'b0;
      have_q  <= 1'b0;
      m_valid <= 1'b0;
      m_max   <= '0;
      m_index <= '0;
      m_nan   <= 1'b0;
    end else begin
      m_valid <= (state_nxt == OUT);
      if (state == OUT) begin
        if (m_ready) begin
          count  <= '0;
          max_q  <= '0;
          idx_q  <= '0;
          nan_q  <= 1'b0;
          have_q <= 1'b0;
        end
      end else if (accept) begin
        max_q  <= max_nxt;
        idx_q  <= idx_nxt;
        nan_q  <= nan_nxt;
        have_q <= have_nxt;
        count  <= last_beat ? count : count + 1'b1;
        if (last_beat) begin
          m_max   <= have_nxt ? max_nxt : FP_NAN_CANON;
          m_index <= have_nxt ? idx_nxt : '0;
          m_nan   <= nan_nxt || !have_nxt;
        end
      end
    end
  end

endmodule

// File: tb/tb_fp_max_reduce.sv
// Randomized + directed bench for fp_max_reduce against an ordering-key reference model.
module tb_fp_max_reduce;

  localparam int ML = 16;
  localparam int IW = $clog2(ML);

  logic          aclk = 1'b0;
  logic          aresetn = 1'b0;
  logic          s_valid = 1'b0;
  logic          s_ready;
  logic [31:0]   s_data = '0;
  logic          s_last = 1'b0;
  logic          m_valid;
  logic          m_ready = 1'b0;
  logic [31:0]   m_max;
  logic [IW-1:0] m_index;
  logic          m_nan;
  logic          hold_mr = 1'b1;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] mx;
    logic [31:0] idx;
    logic        nan;
  } res_t;

  res_t        exp_q[$];
  logic [31:0] vec[$];

  fp_max_reduce #(.MAX_LEN(ML)) dut (
    .aclk    (aclk),
    .aresetn (aresetn),
    .s_valid (s_valid),
    .s_ready (s_ready),
    .s_data  (s_data),
    .s_last  (s_last),
    .m_valid (m_valid),
    .m_ready (m_ready),
    .m_max   (m_max),
    .m_index (m_index),
    .m_nan   (m_nan)
  );

  always #5 aclk = ~aclk;

  always @(posedge aclk) begin
    #1;
    m_ready = hold_mr ? 1'b0 : ($urandom_range(0, 2) != 0);
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, checks=%0d", checks);
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Total order on non-NaN floats: signed magnitude, with both zeros mapping to 0
  function automatic longint fkey(input logic [31:0] x);
    longint m;
    m = longint'(x[30:0]);
    return x[31] ? -m : m;
  endfunction

  function automatic bit fnan(input logic [31:0] x);
    return (x[30:23] == 8'hFF) && (x[22:0] != 0);
  endfunction

  function automatic void model(input logic [31:0] q[$], output logic [31:0] mx,
                                output logic [31:0] idx, output logic nan);
    bit have = 0;
    mx = 32'h7FC0_0000; idx = 0; nan = 0;
    for (int i = 0; i < q.size(); i++) begin
      if (fnan(q[i])) nan = 1;
      else if (!have || fkey(q[i]) > fkey(mx)) begin
        mx = q[i]; idx = i; have = 1;
      end
    end
    if (!have) nan = 1;
  endfunction

  task automatic pin(input string name, input logic [31:0] emx, input logic [31:0] eidx,
                     input logic enan);
    logic [31:0] mx, idx;
    logic        nan;
    model(vec, mx, idx, nan);
    chk({name, "_max"}, mx, emx);
    chk({name, "_idx"}, idx, eidx);
    chk({name, "_nan"}, {31'b0, nan}, {31'b0, enan});
  endtask

  // Every cycle a result is presented it must match the oldest outstanding expectation
  always @(negedge aclk) begin
    if (aresetn && m_valid) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_m_valid", {31'b0, m_valid}, 32'd0);
      end else begin
        chk("m_max", m_max, exp_q[0].mx);
        chk("m_index", {{(32-IW){1'b0}}, m_index}, exp_q[0].idx);
        chk("m_nan", {31'b0, m_nan}, {31'b0, exp_q[0].nan});
        chk("s_ready_in_out", {31'b0, s_ready}, 32'd0);
        if (m_ready) void'(exp_q.pop_front());
      end
    end
  end

  task automatic drive_beat(input logic [31:0] d, input logic last);
    int n = 0;
    if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 2)) @(negedge aclk);
    s_valid = 1'b1; s_data = d; s_last = last;
    while (!s_ready && n < 300) begin @(negedge aclk); n++; end
    chk("s_ready_wait", {31'b0, (n < 300)}, 32'd1);
    @(negedge aclk);
    s_valid = 1'b0; s_last = 1'b0;
  endtask

  task automatic send_vec(input bit use_last);
    res_t r;
    model(vec, r.mx, r.idx, r.nan);
    exp_q.push_back(r);
    for (int i = 0; i < vec.size(); i++) begin
      drive_beat(vec[i], use_last && (i == vec.size() - 1));
      if (i == vec.size() - 1) chk("m_valid_latency", {31'b0, m_valid}, 32'd1);
    end
  endtask

  task automatic drain();
    int n = 0;
    while ((exp_q.size() != 0 || m_valid) && n < 500) begin @(negedge aclk); n++; end
    chk("drain", {31'b0, (n < 500)}, 32'd1);
  endtask

  function automatic logic [31:0] rnd_val(input logic [31:0] prev);
    logic s;
    s = 1'($urandom_range(0, 1));
    case ($urandom_range(0, 9))
      0: return {s, 8'hFF, 23'($urandom_range(1, 32'h7FFFFF))};
      1: return {s, 31'h0};
      2: return {s, 8'hFF, 23'h0};
      3: return {s, 8'h00, 23'($urandom)};
      4: return prev;
      5: return {s, 8'h80, 23'($urandom_range(0, 3))};
      default: return $urandom;
    endcase
  endfunction

  initial begin
    // reset state
    repeat (2) @(negedge aclk);
    chk("rst_s_ready", {31'b0, s_ready}, 32'd0);
    chk("rst_m_valid", {31'b0, m_valid}, 32'd0);
    chk("rst_m_max", m_max, 32'd0);
    chk("rst_m_index", {{(32-IW){1'b0}}, m_index}, 32'd0);
    chk("rst_m_nan", {31'b0, m_nan}, 32'd0);
    aresetn = 1'b1;
    @(negedge aclk);
    hold_mr = 1'b0;

    vec = '{32'h3FC00000, 32'h40200000, 32'h3FC00000};
    pin("v_pos", 32'h40200000, 1, 0);
    send_vec(1);
    vec = '{32'hC0000000, 32'hBF000000, 32'hBF800000};
    pin("v_neg", 32'hBF000000, 1, 0);
    send_vec(1);
    vec = '{32'h00000000, 32'h80000000};
    pin("v_zero", 32'h00000000, 0, 0);
    send_vec(1);
    vec = '{32'h40400000, 32'h40400000};
    pin("v_tie", 32'h40400000, 0, 0);
    send_vec(1);
    vec = '{32'h7FC00000, 32'h3F800000, 32'h7F800001};
    pin("v_nan", 32'h3F800000, 1, 1);
    send_vec(1);
    vec = '{32'h7FC00000, 32'hFF800001};
    pin("v_allnan", 32'h7FC00000, 0, 1);
    send_vec(1);
    vec = '{32'h40000000};
    pin("v_single", 32'h40000000, 0, 0);
    send_vec(1);

    // result held for 5 cycles while downstream stalls
    drain();
    hold_mr = 1'b1;
    vec = '{32'h3F800000, 32'h41000000};
    send_vec(1);
    repeat (5) begin
      @(negedge aclk);
      chk("hold_m_valid", {31'b0, m_valid}, 32'd1);
      chk("hold_s_ready", {31'b0, s_ready}, 32'd0);
    end
    hold_mr = 1'b0;

    // forced end after ML beats with no s_last
    vec.delete();
    for (int i = 0; i < ML; i++) vec.push_back(32'h3F800000 + 32'(i * 3 % 7));
    send_vec(0);

    // abort mid-vector
    drain();
    drive_beat(32'h40000000, 1'b0);
    drive_beat(32'h3F800000, 1'b0);
    aresetn = 1'b0;
    @(negedge aclk);
    chk("abort_s_ready", {31'b0, s_ready}, 32'd0);
    chk("abort_m_valid", {31'b0, m_valid}, 32'd0);
    @(negedge aclk);
    aresetn = 1'b1;
    repeat (4) begin
      @(negedge aclk);
      chk("abort_no_result", {31'b0, m_valid}, 32'd0);
    end
    vec = '{32'hFF800000, 32'h7F800000};
    pin("v_inf", 32'h7F800000, 1, 0);
    send_vec(1);

    // randomized vectors
    for (int v = 0; v < 60; v++) begin
      int len;
      bit forced;
      logic [31:0] prev;
      forced = ($urandom_range(0, 7) == 0);
      len = forced ? ML : $urandom_range(1, ML);
      vec.delete();
      prev = $urandom;
      for (int i = 0; i < len; i++) begin
        prev = rnd_val(prev);
        vec.push_back(prev);
      end
      send_vec(!forced);
    end

    drain();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
